// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: op codes, FSM states, op width.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier; bit 0 is folded into the start cycle so
// the final product is ready WIDTH-1 cycles after start.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             running;

    assign running = (cnt != '0) && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            done    <= 1'b0;
        end else if (start) begin
            product <= b[0] ? PW'(a) : '0;
            mcand   <= PW'(a) << 1;
            mplier  <= b >> 1;
            cnt     <= CNT_W'(1);
            done    <= 1'b0;
        end else if (running) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and C/Z/N/V flags.
// Define ALU_SEQ_MUL_EN to make op 111 an iterative multi-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [OP_W-1:0]   op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  y,
    output logic              c,
    output logic              z,
    output logic              n,
    output logic              v
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    state_e           state, state_next;
    op_e              op_sel;
    logic             accept;
    logic             load;
    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   sum, diff, shl, shr;
    logic [WIDTH-1:0] alu_y, res_y;
    logic             alu_c, alu_v, res_c, res_v;

    assign op_sel   = op_e'(op);
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Single-cycle datapath; shifts carry out the last bit pushed past the edge.
    always_comb begin
        sh    = b[SH_W-1:0];
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        shl   = {1'b0, a} << sh;
        shr   = {a, 1'b0} >> sh;
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_y = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y = diff[WIDTH-1:0];
                alu_c = ~diff[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_SHL: begin
                alu_y = shl[WIDTH-1:0];
                alu_c = shl[WIDTH];
            end
            OP_SHR: begin
                alu_y = shr[WIDTH:1];
                alu_c = shr[0];
            end
            default: begin
                alu_y = '0;
            end
        endcase
    end

    // Next-state and result-select logic.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        res_y      = alu_y;
        res_c      = alu_c;
        res_v      = alu_v;
`ifdef ALU_SEQ_MUL_EN
        mul_start  = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op_sel == OP_MUL) begin
                        state_next = ST_BUSY;
                        mul_start  = 1'b1;
                    end else
`endif
                    begin
                        state_next = ST_DONE;
                        load       = 1'b1;
                    end
                end else if ((state == ST_IDLE) || out_ready) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_next = ST_DONE;
                    load       = 1'b1;
                    res_y      = mul_product[WIDTH-1:0];
                    res_c      = |mul_product[2*WIDTH-1:WIDTH];
                    res_v      = |mul_product[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result and flags hold until the next load; reset discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            c         <= 1'b0;
            z         <= 1'b0;
            n         <= 1'b0;
            v         <= 1'b0;
        end else begin
            out_valid <= (state_next == ST_DONE);
            if (load) begin
                y <= res_y;
                c <= res_c;
                z <= (res_y == '0);
                n <= res_y[WIDTH-1];
                v <= res_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: constant vectors, directed handshake/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 8;
    localparam int M = 2 ** W;
`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         c, z, n, v;

    int checks = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .c         (c),
        .z         (z),
        .n         (n),
        .v         (v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+3:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W+3:0] res_now();
        return {y, c, z, n, v};
    endfunction

    // Reference: {y,c,z,n,v} from integer arithmetic on the operand values.
    function automatic logic [W+3:0] model(input int o, input int aa, input int bb);
        int r, yy, cc, vv, sh, sa, sb, s;
        sa = (aa >= M / 2) ? aa - M : aa;
        sb = (bb >= M / 2) ? bb - M : bb;
        sh = bb % W;
        cc = 0;
        vv = 0;
        case (o)
            0: begin r = aa + bb; cc = int'(r >= M); s = sa + sb; vv = int'(s > M/2 - 1 || s < -M/2); end
            1: begin r = aa - bb; cc = int'(aa >= bb); s = sa - sb; vv = int'(s > M/2 - 1 || s < -M/2); end
            2: r = aa & bb;
            3: r = aa | bb;
            4: r = aa ^ bb;
            5: begin r = aa << sh; cc = (sh == 0) ? 0 : (aa >> (W - sh)) & 1; end
            6: begin r = aa >> sh; cc = (sh == 0) ? 0 : (aa >> (sh - 1)) & 1; end
`ifdef ALU_SEQ_MUL_EN
            default: begin r = aa * bb; cc = int'(r >= M); vv = cc; end
`else
            default: r = 0;
`endif
        endcase
        yy = r % M;
        if (yy < 0) yy += M;
        return {W'(yy), 1'(cc), 1'(yy == 0), 1'((yy >> (W - 1)) & 1), 1'(vv)};
    endfunction

    // Present an op at a negedge, hold until accepted, return at the negedge after accept.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        int k = 0;
        op = o; a = aa; b = bb; in_valid = 1'b1;
        #1;
        while (!in_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        if (k >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy);
        lat = 1;
        busy = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W+3:0] exp, input int hold, input string name);
        int lat, busy;
        out_ready = 1'b0;
        issue(o, aa, bb);
        wait_result(lat, busy);
        chk({name, "_lat"}, 32'(lat), 32'((o == 3'd7) ? MUL_LAT : 1));
        chk(name, 32'(res_now()), 32'(exp));
        repeat (hold) begin
            @(negedge clk);
            chk({name, "_hold"}, {19'd0, out_valid, in_ready, res_now()}, {19'd0, 1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_consume"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_clean(input string name);
        int stale = 0;
        #1;
        chk({name, "_rst"}, {19'd0, out_valid, res_now()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk({name, "_stale"}, 32'(stale), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int lat, busy;
        vecs[0]  = '{3'd0, 8'hFF, 8'h01, {8'h00, 4'b1100}};
        vecs[1]  = '{3'd1, 8'h80, 8'h01, {8'h7F, 4'b1001}};
        vecs[2]  = '{3'd1, 8'h01, 8'h02, {8'hFF, 4'b0010}};
        vecs[3]  = '{3'd5, 8'h81, 8'h01, {8'h02, 4'b1000}};
        vecs[4]  = '{3'd6, 8'h81, 8'h00, {8'h81, 4'b0010}};
        vecs[5]  = '{3'd6, 8'h81, 8'h01, {8'h40, 4'b1000}};
        vecs[6]  = '{3'd0, 8'h7F, 8'h01, {8'h80, 4'b0011}};
        vecs[7]  = '{3'd2, 8'hF0, 8'h3C, {8'h30, 4'b0000}};
        vecs[8]  = '{3'd3, 8'hF0, 8'h0F, {8'hFF, 4'b0010}};
        vecs[9]  = '{3'd4, 8'hAA, 8'hAA, {8'h00, 4'b0100}};
        vecs[10] = '{3'd5, 8'h01, 8'h07, {8'h80, 4'b0010}};
        vecs[11] = '{3'd5, 8'h81, 8'h09, {8'h02, 4'b1000}};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {19'd0, out_valid, res_now()}, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));
        end

        // ADD with out_ready held high: a single out_valid pulse.
        out_ready = 1'b1;
        issue(3'd0, 8'hFF, 8'h01);
        chk("add_pulse_on", {19'd0, out_valid, res_now()}, {19'd0, 1'b1, 8'h00, 4'b1100});
        @(negedge clk);
        chk("add_pulse_off", 32'(out_valid), 32'd0);

        // MUL: busy window and latency.
        out_ready = 1'b0;
        issue(3'd7, 8'h10, 8'h11);
        wait_result(lat, busy);
        chk("mul_lat", 32'(lat), 32'(MUL_LAT));
        chk("mul_busy", 32'(busy), 32'(MUL_LAT - 1));
`ifdef ALU_SEQ_MUL_EN
        chk("mul_res", 32'(res_now()), {20'd0, 8'h10, 4'b1001});
`else
        chk("mul_res", 32'(res_now()), {20'd0, 8'h00, 4'b0100});
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Backpressure, then back-to-back accept on release.
        issue(3'd0, 8'h03, 8'h04);
        wait_result(lat, busy);
        repeat (3) begin
            chk("bp_hold", {21'd0, out_valid, in_ready, y}, {21'd0, 1'b1, 1'b0, 8'h07});
            @(negedge clk);
        end
        out_ready = 1'b1;
        op = 3'd2; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
        #1;
        chk("bp_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next", {23'd0, out_valid, y}, {23'd0, 1'b1, 8'h30});
        @(negedge clk);
        chk("bp_drain", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset with a result pending in DONE.
        issue(3'd0, 8'h03, 8'h04);
        wait_result(lat, busy);
        rst_n = 1'b0;
        check_reset_clean("done");

`ifdef ALU_SEQ_MUL_EN
        // Reset during the 4th BUSY cycle, with a nonzero older result held on y.
        run_op(3'd0, 8'h20, 8'h01, model(0, 32'h20, 32'h01), 0, "pre_mul");
        issue(3'd7, 8'h10, 8'h11);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        check_reset_clean("busy");
`endif

        for (int i = 0; i < 150; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ro, ra, rb, model(int'(ro), int'(ra), int'(rb)), int'($urandom_range(0, 2)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 2-bit combinational ALU used in the group processor project. It accepts an operation and two WIDTH-bit operands over a valid/ready input channel and produces a registered result and registered C/Z/N/V flags over a valid/ready output channel. It sits between the decode stage and the register writeback, replacing the combinational ALU. An optional iterative multiplier gives it real multi-cycle behaviour.

## Interface
- WIDTH, 8, operand/result width (≥2, power of two)
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (low $clog2(WIDTH) bits give the shift amount for shifts)
- op  in  3  operation select
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- y  out  WIDTH  result
- c, z, n, v  out  1 each  carry, zero, negative, overflow flags

## Operation
- Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, op≠MUL: compute, register y/flags, go to DONE. On in_valid, op=MUL: latch operands, go to BUSY.
- BUSY: one shift-add step per cycle for WIDTH cycles, then register y/flags and go to DONE. in_ready=0.
- DONE: out_valid=1. y/flags hold stable until out_ready. When out_ready=1, in_ready=1 in the same cycle.
  - A concurrent in_valid starts the next op: DONE again for single-cycle ops, BUSY for MUL.
  - With no concurrent in_valid, return to IDLE.
- Flags: Z = (y==0); N = y[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = no-borrow (a ≥ b unsigned); V = signed overflow.
  - AND/OR/XOR: C=V=0.
  - SHL/SHR: C = last bit shifted out, 0 when the amount is 0; V=0.
  - MUL: unsigned; y = low WIDTH bits of the 2·WIDTH product; C = V = (high half ≠ 0).
- in_valid while in_ready=0 is ignored. The producer holds its request.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, out_valid=0, y=0, c=z=n=v=0, in_ready=1 once in IDLE.
- Single-cycle op accepted at edge T: out_valid=1 after edge T+1's register update, i.e. latency 1 cycle.
- MUL accepted at edge T: out_valid=1 after WIDTH+1 cycles.
- Throughput with out_ready=1: one single-cycle op per clock; one MUL per WIDTH+1 clocks.
- Reset mid-BUSY or mid-DONE: the partial or pending result is discarded. No out_valid pulse follows reset release.

## Configuration
- ALU_SEQ_MUL_EN defined: op 111 is the iterative multiply described above. The BUSY state and the multiplier sub-module are present.
- ALU_SEQ_MUL_EN undefined: op 111 completes in one cycle with y=0, z=1, c=n=v=0. The BUSY state and the multiplier are not compiled. in_ready is never low outside backpressure.

## Structure
- alu_pkg: op_e enum (the 8 op codes), state_e enum (IDLE/BUSY/DONE), and the 3-bit op width constant.
- Sub-module alu_mul_iter (only under ALU_SEQ_MUL_EN):
  - WIDTH-parameterised shift-add unsigned multiplier.
  - Ports: start, a, b in; done and a 2·WIDTH product out.
  - Internal step counter of $clog2(WIDTH)+1 bits.
- alu_seq: FSM, combinational datapath for single-cycle ops, flag logic, output registers.

## Test plan (WIDTH=8)
- ADD a=8'hFF, b=8'h01, out_ready=1 → one cycle later y=8'h00, c=1, z=1, n=0, v=0, out_valid for one cycle.
- SUB a=8'h80, b=8'h01 → y=8'h7F, c=1, z=0, n=0, v=1. Then SUB a=8'h01, b=8'h02 → y=8'hFF, c=0, n=1, v=0.
- SHL a=8'h81, b=8'h01 → y=8'h02, c=1. SHR a=8'h81, b=8'h00 → y=8'h81, c=0, n=1.
- MUL a=8'h10, b=8'h11 (macro on) → in_ready=0 for 8 cycles; out_valid 9 cycles after accept; y=8'h10, c=v=1. Macro off: same stimulus gives y=8'h00, z=1 after 1 cycle.
- Backpressure: ADD 3+4 with out_ready=0 for 3 cycles → y=8'h07 stable, out_valid=1, in_ready=0. Release out_ready together with in_valid for AND 8'hF0&8'h3C → next cycle y=8'h30, no bubble.
- Reset at BUSY cycle 4 of a MUL → immediately out_valid=0, y=0, flags 0. After release: in_ready=1 and no stale out_valid.
